universal_shift_reg: RTL
========================

// Module: universal_shift_reg
// PURPOSE
//  WIDTH-bit universal register built from d-flops, the registered successor to the team's level-sensitive storage cells.
//  Supports hold, parallel load, clear, logical shift and rotate in both directions.
//  A serial-bit counter pulses word_done after WIDTH consecutive serial shifts.
//  Used as a serialiser/deserialiser and general-purpose register in datapaths.
// PARAMETERS
//  WIDTH    8   register width in bits; legal range 2..64
//  CNT_W    $clog2(WIDTH+1)   width of bit counter (derived localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  reset      in   1      synchronous, active-high; dominates all other inputs
//  enable     in   1      1 = execute mode this cycle; 0 = hold all state
//  mode       in   3      operation select (see BEHAVIOUR)
//  d          in   WIDTH  parallel load data
//  sin_r      in   1      serial in, enters LSB on shift-left
//  sin_l      in   1      serial in, enters MSB on shift-right
//  q          out  WIDTH  register contents
//  sout_l     out  1      = q[WIDTH-1] (combinational from q)
//  sout_r     out  1      = q[0] (combinational from q)
//  bit_cnt    out  CNT_W  serial shifts since last load/clear/word_done
//  word_done  out  1      registered 1-cycle pulse
//  parity     out  1      see CONFIGURATION
// BEHAVIOUR
//  - All state updates on posedge clk only; no latch inference anywhere.
//  - reset=1 at an edge: q=0, bit_cnt=0, word_done=0, regardless of enable/mode.
//  - enable=0: q and bit_cnt hold; word_done=0 next cycle.
//  - enable=1, mode:
//      000 HOLD    q holds
//      001 SHL     q <= {q[W-2:0], sin_r}; counts
//      010 SHR     q <= {sin_l, q[W-1:1]}; counts
//      011 ROL     q <= {q[W-2:0], q[W-1]}; no count
//      100 ROR     q <= {q[0], q[W-1:1]}; no count
//      101 LOAD    q <= d; bit_cnt <= 0
//      110 CLEAR   q <= 0; bit_cnt <= 0
//      111 HOLD    reserved, identical to 000
//  - Counting modes (SHL/SHR):
//      bit_cnt < WIDTH-1: bit_cnt+1, word_done=0
//      bit_cnt == WIDTH-1: bit_cnt <= 0, word_done=1 for exactly one cycle
//  - All other modes, or enable=0: bit_cnt unchanged unless LOAD/CLEAR; word_done=0.
//  - Latency: q, bit_cnt and word_done reflect an operation 1 cycle after the sampling edge.
//  - Direction changes mid-word (SHL then SHR) keep counting from the current bit_cnt.
//  - Reset mid-word discards the partial count.
//  - bit_cnt never exceeds WIDTH-1.
// CONFIGURATION
//  USR_PARITY_EN defined:
//    - parity is a registered even-parity bit (^ of next q), updated with q.
//    - parity resets to 0.
//  USR_PARITY_EN undefined:
//    - parity tied to 1'b0; no parity flop.
// STRUCTURE
//  - Package usr_pkg:
//      mode localparams USR_HOLD, USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_LOAD, USR_CLEAR, USR_RSVD (3-bit).
//  - One sub-module, usr_bit_counter: CNT_W counter with inc/clr inputs, wrap at WIDTH-1, word_done pulse output.
//  - Top-level: next-q mux plus flop bank.
// TESTING (WIDTH=8)
//  1. reset=1 with enable=1, mode=LOAD, d=8'hFF -> q=00, bit_cnt=0, word_done=0 after the edge.
//  2. LOAD d=8'hA5, then ROL x1 -> q=4B; ROR x1 -> q=A5; bit_cnt stays 0.
//  3. CLEAR, then SHL 8 cycles with sin_r=1,0,1,1,0,0,1,0 -> q=B2; word_done high only on the cycle after the 8th shift; bit_cnt=0.
//  4. SHR 3 cycles, enable=0 for 2 cycles, SHR 5 more -> bit_cnt 3,3,3 then wraps; word_done after the 8th counted shift.
//  5. Mid-word reset after 5 SHL shifts -> q=00, bit_cnt=0; the next 8 shifts are needed for word_done.
//  6. With USR_PARITY_EN: LOAD 8'h07 -> parity=1; LOAD 8'h03 -> parity=0. Without the macro -> parity always 0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode encodings and helpers for the universal shift register.
package usr_pkg;

  localparam logic [2:0] USR_HOLD  = 3'b000;
  localparam logic [2:0] USR_SHL   = 3'b001;
  localparam logic [2:0] USR_SHR   = 3'b010;
  localparam logic [2:0] USR_ROL   = 3'b011;
  localparam logic [2:0] USR_ROR   = 3'b100;
  localparam logic [2:0] USR_LOAD  = 3'b101;
  localparam logic [2:0] USR_CLEAR = 3'b110;
  localparam logic [2:0] USR_RSVD  = 3'b111;

  function automatic logic even_parity(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/usr_bit_counter.sv
// Serial-bit counter: counts shifts, wraps at WIDTH-1 and emits a one-cycle word_done pulse.
module usr_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // count register and registered completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= {CNT_W{1'b0}};
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (clr) begin
        cnt <= {CNT_W{1'b0}};
      end else if (inc) begin
        if (cnt == LAST) begin
          cnt       <= {CNT_W{1'b0}};
          word_done <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= cnt;
      end
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, load, clear, shift and rotate with a serial-bit counter.
// Optional registered even-parity output enabled by defining USR_PARITY_EN.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done,
  output logic             parity
);

  logic [WIDTH-1:0] next_q;
  logic             cnt_inc;
  logic             cnt_clr;

  // next-state selection for the register bank and counter controls
  always_comb begin
    next_q  = q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (enable) begin
      case (mode)
        USR_SHL: begin
          next_q  = {q[WIDTH-2:0], sin_r};
          cnt_inc = 1'b1;
        end
        USR_SHR: begin
          next_q  = {sin_l, q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        USR_ROL:   next_q = {q[WIDTH-2:0], q[WIDTH-1]};
        USR_ROR:   next_q = {q[0], q[WIDTH-1:1]};
        USR_LOAD: begin
          next_q  = d;
          cnt_clr = 1'b1;
        end
        USR_CLEAR: begin
          next_q  = {WIDTH{1'b0}};
          cnt_clr = 1'b1;
        end
        default:   next_q = q;
      endcase
    end else begin
      next_q = q;
    end
  end

  // register bank
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= next_q;
    end
  end

  usr_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk       (clk),
    .reset     (reset),
    .inc       (cnt_inc),
    .clr       (cnt_clr),
    .cnt       (bit_cnt),
    .word_done (word_done)
  );

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

`ifdef USR_PARITY_EN
  // parity tracks the value being written into q
  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else begin
      parity <= even_parity(64'(next_q));
    end
  end
`else
  assign parity = 1'b0;
`endif

endmodule
